// File: rtl/rgmii_tx_adapter_if.sv
// Byte-stream handshake between the MAC/packet side and the RGMII transmit adapter.
//   in_data  : byte to transmit
//   in_er    : per-byte error flag
//   in_last  : final byte of a frame
//   in_valid : byte present
//   in_ready : adapter can accept a byte (FIFO not full)
// master = MAC side (drives the byte), slave = adapter (drives in_ready).
interface rgmii_tx_adapter_if;
  logic [7:0] in_data;
  logic       in_er;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_er, output in_last, output in_valid,
                  input  in_ready);
  modport slave  (input  in_data, input  in_er, input  in_last, input  in_valid,
                  output in_ready);
endinterface

// File: rtl/rgmii_tx_adapter.sv
// Multi-speed RGMII transmit adapter with a byte FIFO. Runs from the 125 MHz
// transmit clock and produces rise/fall bit pairs for the ODDR primitives that
// drive rgmii_td, rgmii_tx_ctl and rgmii_txc at 1000/100/10 Mb/s.
// Ports:
//   clk, reset        : 125 MHz clock, synchronous active-high reset
//   speed_selection   : 1x = gigabit, 01 = 100 Mb/s, 00 = 10 Mb/s
//   bus (slave)       : byte stream in (in_data/in_er/in_last/in_valid), in_ready out
//   td_rise/td_fall   : ODDR data for rgmii_td
//   ctl_rise/ctl_fall : ODDR data for rgmii_tx_ctl
//   txc_rise/txc_fall : ODDR data for rgmii_txc
//   tx_busy           : transmitter not idle
//   underrun          : one-cycle pulse per inserted error slot
module rgmii_tx_adapter #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_100    = 5,
  parameter int unsigned DIV_10     = 50,
  parameter int unsigned IFG_BYTES  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         speed_selection,
  rgmii_tx_adapter_if.slave  bus,
  output logic [3:0]         td_rise,
  output logic [3:0]         td_fall,
  output logic               ctl_rise,
  output logic               ctl_fall,
  output logic               txc_rise,
  output logic               txc_fall,
  output logic               tx_busy,
  output logic               underrun
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int unsigned PW      = $clog2(DIV_MAX);
  localparam int unsigned DW      = PW + 1;
  localparam int unsigned IW      = $clog2(IFG_BYTES + 1);

  typedef struct packed {
    logic       last;
    logic       er;
    logic [7:0] data;
  } fifo_entry_t;

  typedef struct packed {
    logic [3:0] td_rise;
    logic [3:0] td_fall;
    logic       ctl_rise;
    logic       ctl_fall;
  } oddr_t;

  typedef enum logic [1:0] {IDLE, DATA, IFG} state_t;

  // Error slot: enable high, error high, data zero -> ctl pair (1,0), td 0.
  localparam fifo_entry_t ERR_SLOT = '{last: 1'b0, er: 1'b1, data: 8'h00};

  // TXC period length in clk cycles for the 10/100 speeds.
  function automatic logic [DW-1:0] div_of(input logic sel100);
    return sel100 ? DW'(DIV_100) : DW'(DIV_10);
  endfunction

  // ODDR data for one byte: gigabit splits nibbles across the edges; 10/100
  // repeats the selected nibble on both edges for a whole TXC period.
  function automatic oddr_t encode(input fifo_entry_t e, input logic hi, input logic gig);
    oddr_t o;
    if (gig) begin
      o.td_rise = e.data[3:0];
      o.td_fall = e.data[7:4];
    end else begin
      o.td_rise = hi ? e.data[7:4] : e.data[3:0];
      o.td_fall = o.td_rise;
    end
    o.ctl_rise = 1'b1;
    o.ctl_fall = ~e.er;
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [1:0]      speed_lat;
  logic [PW-1:0]   pc;
  logic            nib;
  logic [IW-1:0]   ifg_cnt;
  fifo_entry_t     cur;
  oddr_t           oddr_q;

  fifo_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // ---------------------------------------------------------------------------
  // Timing helpers: period/byte boundaries for the current cycle and TXC for
  // the next one. pc_nxt == 0 exactly when wrap is set.
  // ---------------------------------------------------------------------------
  logic            gig_cur;
  logic [DW-1:0]   div_cur;
  logic            wrap;
  logic [PW-1:0]   pc_nxt;
  logic            nib_nxt;
  logic            byte_end;
  logic [1:0]      spd_eff;
  logic            gig_eff;
  logic [DW-1:0]   div_eff;
  logic            txc_rise_nxt;
  logic            txc_fall_nxt;

  always_comb begin
    gig_cur  = speed_lat[1];
    div_cur  = div_of(speed_lat[0]);
    wrap     = gig_cur || (pc == PW'(div_cur - DW'(1)));
    pc_nxt   = wrap ? '0 : PW'(pc + PW'(1));
    nib_nxt  = wrap ? ~nib : nib;
    byte_end = gig_cur || (wrap && nib);
    // New speed takes effect only from an idle period boundary.
    spd_eff  = ((state == IDLE) && wrap) ? speed_selection : speed_lat;
    gig_eff  = spd_eff[1];
    div_eff  = div_of(spd_eff[0]);
    txc_rise_nxt = gig_eff || ({pc_nxt, 1'b0} < div_eff);
    txc_fall_nxt = !gig_eff && ({pc_nxt, 1'b1} < div_eff);
  end

  // ---------------------------------------------------------------------------
  // FIFO handshake and pop decision
  // ---------------------------------------------------------------------------
  logic            empty;
  logic            push;
  logic            launch;
  logic            advance;
  logic            pop;
  logic [CW-1:0]   count_nxt;
  fifo_entry_t     head;

  always_comb begin
    empty     = (count == '0);
    push      = bus.in_valid && bus.in_ready;
    head      = mem[rd_ptr];
    launch    = (state == IDLE) && wrap && !empty;
    advance   = (state == DATA) && byte_end && !cur.last && !empty;
    pop       = launch || advance;
    count_nxt = CW'(count + CW'(push) - CW'(pop));
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_last, bus.in_er, bus.in_data};
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (pop)  rd_ptr <= AW'(rd_ptr + AW'(1));
      count        <= count_nxt;
      bus.in_ready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM with registered ODDR outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      speed_lat <= speed_selection;
      pc        <= '0;
      nib       <= 1'b0;
      ifg_cnt   <= '0;
      cur       <= '0;
      oddr_q    <= '0;
      txc_rise  <= 1'b0;
      txc_fall  <= 1'b0;
      tx_busy   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      speed_lat <= spd_eff;
      pc        <= pc_nxt;
      nib       <= nib_nxt;
      txc_rise  <= txc_rise_nxt;
      txc_fall  <= txc_fall_nxt;
      underrun  <= 1'b0;
      oddr_q    <= '0;

      case (state)
        IDLE: begin
          if (launch) begin
            state   <= DATA;
            cur     <= head;
            nib     <= 1'b0;
            tx_busy <= 1'b1;
            oddr_q  <= encode(head, 1'b0, gig_eff);
          end
        end

        DATA: begin
          // Mid-byte: keep the byte, switching to the high nibble at 10/100.
          oddr_q <= encode(cur, nib_nxt, gig_eff);
          if (byte_end) begin
            if (cur.last) begin
              state   <= IFG;
              ifg_cnt <= IW'(IFG_BYTES);
              oddr_q  <= '0;
            end else if (!empty) begin
              cur    <= head;
              oddr_q <= encode(head, 1'b0, gig_eff);
            end else begin
              // Nothing to send: fill the byte-time with an error slot.
              cur      <= ERR_SLOT;
              oddr_q   <= encode(ERR_SLOT, 1'b0, gig_eff);
              underrun <= 1'b1;
            end
          end
        end

        IFG: begin
          if (byte_end) begin
            if (ifg_cnt <= IW'(1)) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end else begin
              ifg_cnt <= IW'(ifg_cnt - IW'(1));
            end
          end
        end

        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign td_rise  = oddr_q.td_rise;
  assign td_fall  = oddr_q.td_fall;
  assign ctl_rise = oddr_q.ctl_rise;
  assign ctl_fall = oddr_q.ctl_fall;

endmodule

// File: tb/tb_rgmii_tx_adapter.sv
// Directed testbench for rgmii_tx_adapter: reset, gigabit framing with IFG and
// error byte, underrun slots, 100 Mb/s nibbles and TXC, 10 Mb/s backpressure
// with a mid-frame speed change, and reset in the middle of a frame.
module tb_rgmii_tx_adapter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] speed_selection;
  logic [3:0] td_rise, td_fall;
  logic       ctl_rise, ctl_fall, txc_rise, txc_fall, tx_busy, underrun;

  always #4 clk = ~clk;

  rgmii_tx_adapter_if bus ();

  rgmii_tx_adapter #(
    .FIFO_DEPTH(16), .DIV_100(5), .DIV_10(50), .IFG_BYTES(12)
  ) dut (
    .clk(clk), .reset(reset), .speed_selection(speed_selection), .bus(bus),
    .td_rise(td_rise), .td_fall(td_fall), .ctl_rise(ctl_rise), .ctl_fall(ctl_fall),
    .txc_rise(txc_rise), .txc_fall(txc_fall), .tx_busy(tx_busy), .underrun(underrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o(input logic [3:0] r, input logic [3:0] f,
                                    input logic cr, input logic cf);
    return 32'({r, f, cr, cf});
  endfunction

  function automatic logic [31:0] obs();
    return 32'({td_rise, td_fall, ctl_rise, ctl_fall});
  endfunction

  task automatic put(input logic v, input logic [7:0] d, input logic er, input logic last);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_er    = er;
    bus.in_last  = last;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n = 0;
    while (tx_busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_busy), 32'(0));
  endtask

  task automatic wait_ctl(input int max_cycles, input string tag);
    int n = 0;
    while (!ctl_rise && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ctl_rise), 32'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] e;
  logic [1:0]  txc_pat [5];
  int          idx, fall_idx, nrise;
  int          rise_c [4];
  logic        prev_rdy, prev_txc, seen;

  initial begin
    txc_pat[0] = 2'b11; txc_pat[1] = 2'b11; txc_pat[2] = 2'b10;
    txc_pat[3] = 2'b00; txc_pat[4] = 2'b00;
    reset = 1'b1;
    speed_selection = 2'b10;
    put(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset values
    idle_cycles(3);
    check("rst_out", obs(), 32'(0));
    check("rst_txc", 32'({txc_rise, txc_fall}), 32'(0));
    check("rst_ready", 32'(bus.in_ready), 32'(0));
    check("rst_busy_und", 32'({tx_busy, underrun}), 32'(0));
    reset = 1'b0;
    idle_cycles(2);
    check("post_rst_ready", 32'(bus.in_ready), 32'(1));
    check("post_rst_txc", 32'({txc_rise, txc_fall}), 32'(2'b10));
    idle_cycles(2);

    // Gigabit back-to-back frame, then a queued two-byte frame with an error byte
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      case (c)
        2:  e = o(4'h5, 4'h5, 1'b1, 1'b1);
        3:  e = o(4'h5, 4'hD, 1'b1, 1'b1);
        4:  e = o(4'h7, 4'hA, 1'b1, 1'b1);
        18: e = o(4'h2, 4'h1, 1'b1, 1'b0);
        19: e = o(4'h4, 4'h3, 1'b1, 1'b1);
        default: e = 32'(0);
      endcase
      check($sformatf("gig_out_c%0d", c), obs(), e);
      check($sformatf("gig_busy_c%0d", c), 32'(tx_busy), 32'((c >= 2 && c <= 16) || c >= 18));
      check($sformatf("gig_txc_c%0d", c), 32'({txc_rise, txc_fall}), 32'(2'b10));
      case (c)
        0: put(1'b1, 8'h55, 1'b0, 1'b0);
        1: put(1'b1, 8'hD5, 1'b0, 1'b0);
        2: put(1'b1, 8'hA7, 1'b0, 1'b1);
        3: put(1'b1, 8'h12, 1'b1, 1'b0);
        4: put(1'b1, 8'h34, 1'b0, 1'b1);
        default: put(1'b0, 8'h00, 1'b0, 1'b0);
      endcase
    end
    wait_idle(100, "gig_idle_timeout");
    idle_cycles(2);

    // Underrun: two empty byte-times inside a 4-byte gigabit frame
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      case (c)
        2: e = o(4'h1, 4'h6, 1'b1, 1'b1);
        3: e = o(4'h2, 4'h7, 1'b1, 1'b1);
        4: e = o(4'h0, 4'h0, 1'b1, 1'b0);
        5: e = o(4'h0, 4'h0, 1'b1, 1'b0);
        6: e = o(4'h3, 4'h8, 1'b1, 1'b1);
        7: e = o(4'h4, 4'h9, 1'b1, 1'b1);
        default: e = 32'(0);
      endcase
      check($sformatf("ur_out_c%0d", c), obs(), e);
      check($sformatf("ur_pulse_c%0d", c), 32'(underrun), 32'(c == 4 || c == 5));
      case (c)
        0: put(1'b1, 8'h61, 1'b0, 1'b0);
        1: put(1'b1, 8'h72, 1'b0, 1'b0);
        4: put(1'b1, 8'h83, 1'b0, 1'b0);
        5: put(1'b1, 8'h94, 1'b0, 1'b1);
        default: put(1'b0, 8'h00, 1'b0, 1'b0);
      endcase
    end
    wait_idle(100, "ur_idle_timeout");

    // 100 Mb/s: single-byte frame 0x3C, nibbles aligned to TXC periods, 120-cycle IFG
    speed_selection = 2'b01;
    idle_cycles(5);
    put(1'b1, 8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    wait_ctl(20, "m100_start_timeout");
    seen = 1'b0;
    for (int k = 0; k <= 130; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 10) begin
        e = (k < 5) ? o(4'hC, 4'hC, 1'b1, 1'b1) : o(4'h3, 4'h3, 1'b1, 1'b1);
        check($sformatf("m100_out_k%0d", k), obs(), e);
        check($sformatf("m100_txc_k%0d", k), 32'({txc_rise, txc_fall}), 32'(txc_pat[k % 5]));
      end else if (k < 130) begin
        if (ctl_rise || ctl_fall) seen = 1'b1;
      end
      if (k == 12) check("m100_ifg_txc", 32'({txc_rise, txc_fall}), 32'(2'b10));
      if (k == 10) check("m100_ifg_start", obs(), 32'(0));
      if (k == 129) check("m100_ifg_busy", 32'(tx_busy), 32'(1));
      if (k == 130) check("m100_ifg_end", 32'(tx_busy), 32'(0));
    end
    check("m100_ifg_quiet", 32'(seen), 32'(0));

    // 10 Mb/s backpressure, speed switched to gigabit mid-frame
    speed_selection = 2'b00;
    idle_cycles(60);
    prev_txc = txc_rise;
    seen = 1'b0;
    for (int n = 0; n < 120 && !seen; n++) begin
      @(negedge clk);
      if (txc_rise && !prev_txc) seen = 1'b1;
      prev_txc = txc_rise;
    end
    check("m10_txc_found", 32'(seen), 32'(1));
    idx = 0; fall_idx = -1; nrise = 0; prev_rdy = 1'b1;
    for (int c = 0; c < 3000 && idx < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 50)  check("bp_b0_lo", obs(), o(4'h1, 4'h1, 1'b1, 1'b1));
      if (c == 100) check("bp_b0_hi", obs(), o(4'h3, 4'h3, 1'b1, 1'b1));
      if (c == 200) speed_selection = 2'b10;
      if (!bus.in_ready && prev_rdy && fall_idx < 0) fall_idx = idx;
      if (bus.in_ready && !prev_rdy && nrise < 4) begin
        rise_c[nrise] = c;
        nrise++;
      end
      prev_rdy = bus.in_ready;
      put(1'b1, 8'(8'h31 + idx), 1'b0, idx == 19);
      if (bus.in_ready) idx++;
    end
    @(negedge clk);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp_all_sent", 32'(idx), 32'(20));
    check("bp_full_at", 32'(fall_idx), 32'(16));
    check("bp_rise0", 32'(rise_c[0]), 32'(50));
    check("bp_rise1", 32'(rise_c[1] - rise_c[0]), 32'(100));
    check("bp_rise2", 32'(rise_c[2] - rise_c[1]), 32'(100));
    check("bp_rise3", 32'(rise_c[3] - rise_c[2]), 32'(100));
    wait_idle(4000, "bp_idle_timeout");
    idle_cycles(60);

    // Next frame goes out at gigabit
    put(1'b1, 8'h9E, 1'b0, 1'b1);
    @(negedge clk);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("sw_gig_byte", obs(), o(4'hE, 4'h9, 1'b1, 1'b1));
    check("sw_gig_txc", 32'({txc_rise, txc_fall}), 32'(2'b10));
    @(negedge clk);
    check("sw_gig_end", obs(), 32'(0));
    wait_idle(100, "sw_idle_timeout");

    // Reset in the middle of a 100 Mb/s frame
    speed_selection = 2'b01;
    idle_cycles(20);
    put(1'b1, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    put(1'b1, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    put(1'b1, 8'h33, 1'b0, 1'b1);
    @(negedge clk);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    wait_ctl(20, "mr_start_timeout");
    idle_cycles(3);
    reset = 1'b1;
    @(negedge clk);
    check("mr_out", obs(), 32'(0));
    check("mr_txc", 32'({txc_rise, txc_fall}), 32'(0));
    check("mr_ready_busy_und", 32'({bus.in_ready, tx_busy, underrun}), 32'(0));
    reset = 1'b0;
    idle_cycles(2);
    check("mr_ready_after", 32'(bus.in_ready), 32'(1));
    check("mr_busy_after", 32'(tx_busy), 32'(0));
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ctl_rise || ctl_fall || tx_busy) seen = 1'b1;
    end
    check("mr_discarded", 32'(seen), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgmii_tx_adapter.md
# rgmii_tx_adapter

Multi-speed RGMII transmit adapter with a byte FIFO. It accepts a byte stream from the MAC/packet side and produces the per-cycle rise and fall bit pairs for the ODDR output primitives that drive rgmii_td, rgmii_tx_ctl and rgmii_txc. It runs entirely from the 125 MHz transmit clock and generates 125/25/2.5 MHz TXC through DDR bit patterns. Added over the existing gigabit-only TX path: speed adaptation, backpressure, inter-frame gap enforcement and underrun signalling.

## Interface
Parameters:
- FIFO_DEPTH, 16, byte FIFO depth; power of two, at least 4.
- DIV_100, 5, clk cycles per TXC period at 100 Mb/s.
- DIV_10, 50, clk cycles per TXC period at 10 Mb/s.
- IFG_BYTES, 12, minimum idle byte-times between frames.

Ports:
- clk  in  1  transmit clock, 125 MHz.
- reset  in  1  synchronous, active-high.
- speed_selection  in  2  1x = gigabit, 01 = 100 Mb/s, 00 = 10 Mb/s.
- in_data  in  8  byte to transmit.
- in_er  in  1  per-byte error flag.
- in_last  in  1  marks the final byte of a frame.
- in_valid  in  1  byte present on the input.
- in_ready  out  1  FIFO can accept a byte (not full).
- td_rise / td_fall  out  4 each  ODDR data for rgmii_td, rising half then falling half.
- ctl_rise / ctl_fall  out  1 each  ODDR data for rgmii_tx_ctl.
- txc_rise / txc_fall  out  1 each  ODDR data for rgmii_txc.
- tx_busy  out  1  state is not IDLE.
- underrun  out  1  one-cycle pulse for each error byte slot inserted.

## Operation
- **Input handshake:** a byte is written when in_valid and in_ready are both high. The FIFO stores {last, er, data} (10 bits). in_ready = !full.
- **Speed latch:** speed_selection is latched only in IDLE, at a TXC period boundary. That boundary is every cycle at gigabit, otherwise when period counter pc = 0. Changes made mid-frame or mid-IFG take effect at the next IDLE boundary.
- **Period counter:**
  - pc counts 0..DIV-1 at 10/100 and wraps.
  - At gigabit, pc is held at 0.
  - A nibble phase bit (low/high) toggles at each wrap.
- **TXC generation:**
  - Gigabit: txc_rise = 1, txc_fall = 0.
  - 10/100: half-index h = 2·pc for the rise bit and 2·pc+1 for the fall bit; TXC bit = (h < DIV).
  - DIV_100 = 5 gives (1,1),(1,1),(1,0),(0,0),(0,0).
  - TXC runs in every state, including IDLE.
- **State machine (IDLE, DATA, IFG):**
  - IDLE → DATA at a boundary when the FIFO is non-empty. The FIFO head is popped and launched.
  - DATA: pop the next byte at each byte-time boundary. A byte-time is 1 cycle at gigabit and 2·DIV cycles at 10/100.
  - After the byte flagged last completes, go DATA → IFG, with the IFG counter loaded to IFG_BYTES.
  - IFG → IDLE once IFG_BYTES byte-times of idle have elapsed.
- **Data encoding:**
  - Gigabit: td_rise = d[3:0], td_fall = d[7:4].
  - 10/100: d[3:0] is driven on both td_rise and td_fall for one full TXC period, then d[7:4] for the next period.
  - ctl_rise = en and ctl_fall = en ^ er, held for the whole byte-time.
- **Idle and IFG output:** td = 0, ctl_rise = ctl_fall = 0.
- **Underrun:**
  - Condition: in DATA, a byte is due but the FIFO is empty.
  - Emit an error slot of one byte-time: td = 0, ctl_rise = 1, ctl_fall = 0.
  - Pulse underrun for one cycle and stay in DATA; resume with the next byte when one is available.
  - The frame is corrupt by design.
- **FIFO:** a simultaneous push and pop when full is not allowed, because in_ready is low. A simultaneous push and pop when non-full keeps the count unchanged.

## Timing
- All outputs are registered.
- **During reset:**
  - td = 0, ctl = 0, txc_rise = txc_fall = 0.
  - in_ready = 0, tx_busy = 0, underrun = 0.
  - FIFO emptied, pc = 0, state = IDLE, speed latched from speed_selection.
- TXC begins toggling on the first cycle after reset deasserts.
- **Latency:**
  - Gigabit: a byte written at cycle N into an empty FIFO while in IDLE appears on td/ctl at N+2.
  - 10/100: the first byte appears at N+2 or at the first TXC period boundary after it, whichever is later.
- **Byte spacing:** back-to-back bytes at gigabit leave no gaps when in_valid is held high and the FIFO is non-empty.
- **Reset mid-frame:**
  - The next cycle shows reset values.
  - The partial frame is discarded; no error slot is emitted.
- **Frame size:** a frame consisting of only a last byte is legal and is followed by the IFG.

## Test plan
- **Gigabit back-to-back:** speed=10; write 0x55, 0xD5, 0xA7 (last) on consecutive cycles → (td_rise, td_fall) = (5,5), (5,D), (7,A) on cycles N+2..N+4 with ctl = 1/1. Then ctl = 0 for at least 12 cycles, even with a second frame already queued.
- **100 Mb/s nibbles:** speed=01; write 0x3C (last) → td_rise = td_fall = C for 5 cycles, then 3 for 5 cycles, aligned to pc = 0. TXC pairs repeat (1,1),(1,1),(1,0),(0,0),(0,0). IFG lasts 120 cycles.
- **Error byte:** gigabit byte with in_er=1 → ctl_rise = 1, ctl_fall = 0 for that cycle only.
- **Underrun:** gigabit 4-byte frame; in_valid dropped for 2 cycles after byte 2 → two slots with td = 0 and ctl = 1/0, underrun high for 2 cycles, then bytes 3–4 are sent normally.
- **Backpressure and speed change:**
  - At 10 Mb/s, write 20 bytes continuously → in_ready falls when the FIFO holds 16 bytes and rises after each 100-cycle pop.
  - Switch speed_selection to 10 mid-frame → the frame and its IFG finish at 10 Mb/s; the next frame goes out at gigabit.
- **Reset mid-frame:** assert reset during DATA at 100 Mb/s → the next cycle shows all outputs 0 and in_ready = 0. After release, the FIFO is empty and tx_busy = 0.
